// File: rtl/ram_dp_be_clr.sv
// Simple dual-port synchronous RAM with byte-lane writes, optional output register,
// selectable read-during-write behaviour and a clear engine that zeroes the array after reset.
module ram_dp_be_clr #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int OUT_REG    = 0,
    parameter int RDW_MODE   = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 wr_en,
    input  logic [ADDR_WIDTH-1:0]                wr_addr,
    input  logic [DATA_WIDTH-1:0]                wr_data,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]     wr_be,
    input  logic                                 rd_en,
    input  logic [ADDR_WIDTH-1:0]                rd_addr,
    output logic [DATA_WIDTH-1:0]                rd_data,
    output logic                                 rd_valid,
    input  logic                                 clr_req,
    output logic                                 init_busy
);

    localparam int NB = DATA_WIDTH / BYTE_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   clr_addr_reg;
    logic [ADDR_WIDTH-1:0]   clr_addr_next;
    logic                    clr_we;

    logic                    wr_ok;
    logic                    rd_ok;
    logic                    rdw_hit;

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [NB-1:0]           mem_be;

    logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];
    logic [DATA_WIDTH-1:0]   mem_q_reg;
    logic [DATA_WIDTH-1:0]   byp_mask_reg;
    logic [DATA_WIDTH-1:0]   byp_data_reg;
    logic [DATA_WIDTH-1:0]   wr_mask;
    logic [DATA_WIDTH-1:0]   read_word;

    logic                    valid_s1_reg;
    logic                    have_data_reg;
    logic [DATA_WIDTH-1:0]   data_s1;

    // ------------------------------------------------------------------
    // Clear engine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_CLEAR;
            clr_addr_reg <= '0;
        end else begin
            state_reg    <= state_next;
            clr_addr_reg <= clr_addr_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        clr_addr_next = clr_addr_reg;
        clr_we        = 1'b0;
        case (state_reg)
            ST_CLEAR: begin
                clr_we        = 1'b1;
                clr_addr_next = clr_addr_reg + 1'b1;
                if (clr_addr_reg == LAST_ADDR) begin
                    state_next    = ST_IDLE;
                    clr_addr_next = '0;
                end
            end
            ST_IDLE: begin
                if (clr_req) begin
                    state_next    = ST_CLEAR;
                    clr_addr_next = '0;
                end
            end
        endcase
    end

    assign init_busy = (state_reg == ST_CLEAR);
    assign wr_ok     = wr_en && !init_busy;
    assign rd_ok     = rd_en && !init_busy;

    // ------------------------------------------------------------------
    // Write port: the clear engine takes the port whenever it is running
    // ------------------------------------------------------------------
    always_comb begin
        mem_we    = wr_ok;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
        mem_be    = wr_be;
        if (clr_we) begin
            mem_we    = 1'b1;
            mem_addr  = clr_addr_reg;
            mem_wdata = CLEAR_VALUE;
            mem_be    = '1;
        end
    end

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane_mask
            assign wr_mask[gi*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{wr_be[gi]}};
        end
    endgenerate

    assign rdw_hit = (RDW_MODE != 0) && wr_ok && (wr_addr == rd_addr);

    // Array and read register carry no reset so they map onto block RAM.
    // Non-blocking semantics make the read return the pre-write word; the
    // bypass registers overlay the written lanes afterwards when requested.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_be[i]) begin
                    mem[mem_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
        if (rd_ok) begin
            mem_q_reg    <= mem[rd_addr];
            byp_mask_reg <= rdw_hit ? wr_mask : '0;
            byp_data_reg <= wr_data;
        end
    end

    assign read_word = (mem_q_reg & ~byp_mask_reg) | (byp_data_reg & byp_mask_reg);

    // ------------------------------------------------------------------
    // Read pipeline control
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_s1_reg  <= 1'b0;
            have_data_reg <= 1'b0;
        end else begin
            valid_s1_reg <= rd_ok;
            if (rd_ok) begin
                have_data_reg <= 1'b1;
            end
        end
    end

    // Until the first read after reset the raw RAM register is undefined; show zero.
    assign data_s1 = have_data_reg ? read_word : '0;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] rd_data_reg;
            logic                  rd_valid_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data_reg  <= '0;
                    rd_valid_reg <= 1'b0;
                end else begin
                    rd_valid_reg <= valid_s1_reg;
                    if (valid_s1_reg) begin
                        rd_data_reg <= read_word;
                    end
                end
            end

            assign rd_data  = rd_data_reg;
            assign rd_valid = rd_valid_reg;
        end else begin : g_no_out_reg
            assign rd_data  = data_s1;
            assign rd_valid = valid_s1_reg;
        end
    endgenerate

endmodule

// File: tb/tb_ram_dp_be_clr.sv
// Scoreboard bench: two instances (1-cycle/read-old and 2-cycle/read-new) share one stimulus stream.
module tb_ram_dp_be_clr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic        clr_req;

    logic [31:0] rd_data0, rd_data1;
    logic        rd_valid0, rd_valid1;
    logic        init_busy0, init_busy1;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_dp_be_clr #(.OUT_REG(0), .RDW_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0),
        .clr_req(clr_req), .init_busy(init_busy0)
    );

    ram_dp_be_clr #(.OUT_REG(1), .RDW_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1),
        .clr_req(clr_req), .init_busy(init_busy1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: pop the oldest expectation whenever a DUT presents a result.
    always @(negedge clk) begin
        exp_t e0;
        if (rd_valid0 === 1'b1) begin
            if (q0.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL dut0_unexpected_valid: got rd_valid=1 data %h expected no result (cycle %0d)", rd_data0, cyc);
            end else begin
                e0 = q0.pop_front();
                chk("dut0_rd_data", rd_data0, e0.data);
                chk("dut0_rd_cycle", 32'(cyc), 32'(e0.due));
                $display("dut0 read result %h at cycle %0d", rd_data0, cyc);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e1;
        if (rd_valid1 === 1'b1) begin
            if (q1.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL dut1_unexpected_valid: got rd_valid=1 data %h expected no result (cycle %0d)", rd_data1, cyc);
            end else begin
                e1 = q1.pop_front();
                chk("dut1_rd_data", rd_data1, e1.data);
                chk("dut1_rd_cycle", 32'(cyc), 32'(e1.due));
                $display("dut1 read result %h at cycle %0d", rd_data1, cyc);
            end
        end
    end

    // One clock of stimulus; e0/e1 are the hand-computed results for each instance.
    task automatic op(input logic w, input logic [3:0] wa, input logic [31:0] wd, input logic [3:0] be,
                      input logic r, input logic [3:0] ra, input logic [31:0] e0, input logic [31:0] e1,
                      input logic c);
        exp_t x;
        wr_en   = w;
        wr_addr = wa;
        wr_data = wd;
        wr_be   = be;
        rd_en   = r;
        rd_addr = ra;
        clr_req = c;
        @(posedge clk);
        #1;
        if (r) begin
            x.data = e0; x.due = cyc;     q0.push_back(x);
            x.data = e1; x.due = cyc + 1; q1.push_back(x);
        end
        if (w || r || c)
            $display("op wr=%0b addr=%0d data=%h be=%b rd=%0b addr=%0d clr=%0b", w, wa, wd, be, r, ra, c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
    endtask

    // Counts edges until both instances leave the clear; optionally holds clr_req
    // and pokes a write/read late in the window, both of which must be ignored.
    task automatic wait_clear(input string name, input logic hold_clr, input logic poke);
        int n = 0;
        while ((init_busy0 || init_busy1) && n < 40) begin
            clr_req = hold_clr;
            if (poke && n >= 10 && n <= 13) begin
                wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'hABCDEF01; wr_be = 4'hF;
                rd_en = 1'b1; rd_addr = 4'd2;
            end else begin
                wr_en = 1'b0; rd_en = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
        chk({name, "_busy_cycles"}, 32'(n), 32'd16);
        chk({name, "_busy1_low"}, {31'b0, init_busy1}, 32'd0);
        $display("%s: clear took %0d cycles", name, n);
    endtask

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_en = 1'b0; rd_addr = '0; clr_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy0", {31'b0, init_busy0}, 32'd1);
        chk("reset_busy1", {31'b0, init_busy1}, 32'd1);
        chk("reset_valid0", {31'b0, rd_valid0}, 32'd0);
        chk("reset_valid1", {31'b0, rd_valid1}, 32'd0);
        chk("reset_data0", rd_data0, 32'h0);
        chk("reset_data1", rd_data1, 32'h0);
        rst_n = 1'b1;
        wait_clear("power_up", 1'b0, 1'b0);

        // Every location reads back the clear value, back to back.
        for (int i = 0; i < 16; i++) op(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'(i), 32'h0, 32'h0, 1'b0);

        // Byte-lane merge.
        op(1'b1, 4'd3, 32'hDEADBEEF, 4'b1111, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
        op(1'b1, 4'd3, 32'h00AA0000, 4'b0100, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
        op(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd3, 32'hDEAABEEF, 32'hDEAABEEF, 1'b0);

        // Read-during-write, full word then a single lane.
        op(1'b1, 4'd5, 32'h11111111, 4'b1111, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
        op(1'b1, 4'd5, 32'h22222222, 4'b1111, 1'b1, 4'd5, 32'h11111111, 32'h22222222, 1'b0);
        op(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd5, 32'h22222222, 32'h22222222, 1'b0);
        op(1'b1, 4'd3, 32'h000000CC, 4'b0001, 1'b1, 4'd3, 32'hDEAABEEF, 32'hDEAABECC, 1'b0);
        op(1'b1, 4'd6, 32'h66666666, 4'b1111, 1'b1, 4'd3, 32'hDEAABECC, 32'hDEAABECC, 1'b0);
        op(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd6, 32'h66666666, 32'h66666666, 1'b0);

        // Consecutive reads stream in order without bubbles.
        op(1'b1, 4'd0, 32'h01010101, 4'b1111, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
        op(1'b1, 4'd1, 32'h02020202, 4'b1111, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
        op(1'b1, 4'd2, 32'h03030303, 4'b1111, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
        op(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd0, 32'h01010101, 32'h01010101, 1'b0);
        op(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd1, 32'h02020202, 32'h02020202, 1'b0);
        op(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd2, 32'h03030303, 32'h03030303, 1'b0);
        idle(2);

        // Fill with ones, then clear on request with a same-cycle read of old data.
        for (int i = 0; i < 16; i++) op(1'b1, 4'(i), 32'hFFFFFFFF, 4'hF, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
        op(1'b1, 4'd8, 32'h12345678, 4'hF, 1'b1, 4'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        wait_clear("clr_req", 1'b1, 1'b1);
        chk("hold_through_clear0", rd_data0, 32'hFFFFFFFF);
        chk("hold_through_clear1", rd_data1, 32'hFFFFFFFF);
        for (int i = 0; i < 16; i++) op(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'(i), 32'h0, 32'h0, 1'b0);
        idle(2);

        // Reset in the middle of a clear restarts it from scratch.
        op(1'b1, 4'd4, 32'h44444444, 4'hF, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
        op(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd4, 32'h44444444, 32'h44444444, 1'b0);
        idle(2);
        op(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b1);
        idle(6);
        rst_n = 1'b0;
        #1;
        chk("midclr_reset_data0", rd_data0, 32'h0);
        chk("midclr_reset_data1", rd_data1, 32'h0);
        chk("midclr_reset_valid1", {31'b0, rd_valid1}, 32'd0);
        chk("midclr_reset_busy0", {31'b0, init_busy0}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        wait_clear("reset_restart", 1'b0, 1'b0);
        op(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd4, 32'h0, 32'h0, 1'b0);
        op(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd15, 32'h0, 32'h0, 1'b0);
        idle(4);

        chk("dut0_pending_results", 32'(q0.size()), 32'd0);
        chk("dut1_pending_results", 32'(q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
